// File: rtl/i2s_tx_pkg.sv
// rtl/i2s_tx_pkg.sv - shared audio-path widths and I2S framing defaults
package i2s_tx_pkg;
  localparam int SAMPLE_WIDTH = 16;
  localparam int SLOT_WIDTH   = 32;
  localparam int BCLK_DIV     = 8;
endpackage

// File: rtl/i2s_tx_if.sv
// rtl/i2s_tx_if.sv - stereo frame handshake from the filter chain into the transmitter
interface i2s_tx_if
  import i2s_tx_pkg::*;
#(
  parameter int W = SAMPLE_WIDTH
);
  logic signed [W-1:0] left_in;
  logic signed [W-1:0] right_in;
  logic                frame_valid;
  logic                frame_ready;

  modport master (output left_in, output right_in, output frame_valid, input frame_ready);
  modport slave  (input left_in, input right_in, input frame_valid, output frame_ready);
endinterface

// File: rtl/i2s_tx_bclk_gen.sv
// rtl/i2s_tx_bclk_gen.sv - bclk divider, frame bit position, lrck and fall/load strobes
module i2s_tx_bclk_gen
  import i2s_tx_pkg::*;
#(
  parameter int SLOT_WIDTH = i2s_tx_pkg::SLOT_WIDTH,
  parameter int BCLK_DIV   = i2s_tx_pkg::BCLK_DIV
) (
  input  logic clock,
  input  logic reset,
  output logic o_bclk,
  output logic o_lrck,
  output logic o_fall,
  output logic o_load
);
  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int PW = $clog2(2 * SLOT_WIDTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [PW-1:0] POS_LAST = PW'(2 * SLOT_WIDTH - 1);
  localparam logic [PW-1:0] POS_HALF = PW'(SLOT_WIDTH);

  logic [DW-1:0] r_div;
  logic [PW-1:0] r_pos;
  logic          r_bclk;
  logic          r_lrck;
  logic [PW-1:0] w_pos_next;
  logic          w_fall;

  // A fall is the terminal-count edge while bclk is high; the top shifts data on it too.
  assign w_fall     = (r_div == DIV_LAST) && r_bclk;
  assign w_pos_next = (r_pos == POS_LAST) ? '0 : r_pos + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_div  <= '0;
      r_bclk <= 1'b0;
      r_pos  <= POS_LAST;
      r_lrck <= 1'b0;
    end else begin
      if (r_div == DIV_LAST) begin
        r_div  <= '0;
        r_bclk <= ~r_bclk;
      end else begin
        r_div <= r_div + 1'b1;
      end
      if (w_fall) begin
        r_pos  <= w_pos_next;
        r_lrck <= (w_pos_next >= POS_HALF);
      end
    end
  end

  assign o_bclk = r_bclk;
  assign o_lrck = r_lrck;
  assign o_fall = w_fall;
  assign o_load = w_fall && (r_pos == POS_LAST);
endmodule

// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - Philips I2S stereo transmitter with one-frame buffer
module i2s_tx
  import i2s_tx_pkg::*;
#(
  parameter int SAMPLE_WIDTH = i2s_tx_pkg::SAMPLE_WIDTH,
  parameter int SLOT_WIDTH   = i2s_tx_pkg::SLOT_WIDTH,
  parameter int BCLK_DIV     = i2s_tx_pkg::BCLK_DIV
) (
  input  logic     clock,
  input  logic     reset,
  i2s_tx_if.slave  i_frame,
  output logic     o_bclk,
  output logic     o_lrck,
  output logic     o_sdata,
  output logic     o_frame_start,
  output logic     o_underrun
);
  localparam int SW  = 2 * SLOT_WIDTH;
  localparam int PAD = SLOT_WIDTH - SAMPLE_WIDTH - 1;

  logic                    w_fall;
  logic                    w_load;
  logic                    w_accept;
  logic [SAMPLE_WIDTH-1:0] w_load_l;
  logic [SAMPLE_WIDTH-1:0] w_load_r;
  logic [SW-1:0]           w_load_word;

  logic                    r_buf_full;
  logic [SAMPLE_WIDTH-1:0] r_buf_l;
  logic [SAMPLE_WIDTH-1:0] r_buf_r;
  logic [SW-1:0]           r_shift;
  logic                    r_sdata;
  logic                    r_frame_start;
  logic                    r_underrun;

  i2s_tx_bclk_gen #(
    .SLOT_WIDTH (SLOT_WIDTH),
    .BCLK_DIV   (BCLK_DIV)
  ) u_bclk_gen (
    .clock  (clock),
    .reset  (reset),
    .o_bclk (o_bclk),
    .o_lrck (o_lrck),
    .o_fall (w_fall),
    .o_load (w_load)
  );

  assign w_accept = i_frame.frame_valid && !r_buf_full;
  assign w_load_l = r_buf_full ? r_buf_l : '0;
  assign w_load_r = r_buf_full ? r_buf_r : '0;

  // Stored already shifted by one: the leading delay bit goes out on the load edge itself.
  assign w_load_word = {w_load_l, {PAD{1'b0}}, 1'b0, w_load_r, {PAD{1'b0}}, 1'b0};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_buf_full    <= 1'b0;
      r_buf_l       <= '0;
      r_buf_r       <= '0;
      r_shift       <= '0;
      r_sdata       <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_frame_start <= w_load;
      r_underrun    <= w_load && !r_buf_full;
      if (w_load) begin
        r_shift <= w_load_word;
        r_sdata <= 1'b0;
      end else if (w_fall) begin
        r_shift <= {r_shift[SW-2:0], 1'b0};
        r_sdata <= r_shift[SW-1];
      end
      // Accept only happens while empty, so it never collides with a buffered load.
      if (w_accept) begin
        r_buf_full <= 1'b1;
        r_buf_l    <= i_frame.left_in;
        r_buf_r    <= i_frame.right_in;
      end else if (w_load) begin
        r_buf_full <= 1'b0;
      end
    end
  end

  assign i_frame.frame_ready = ~r_buf_full;
  assign o_sdata             = r_sdata;
  assign o_frame_start       = r_frame_start;
  assign o_underrun          = r_underrun;
endmodule
